// File: rtl/riscv_csr_dbg_master_if.sv
// Debug-unit request/response bundle for the CSR debug master.
// The debug unit is the master side; the CSR debug master is the slave.
interface riscv_csr_dbg_master_if;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic        dbg_burst_i;
    logic [11:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_last_o;
    logic        dbg_busy_o;

    modport master (
        output dbg_req_i, dbg_we_i, dbg_burst_i,
        output dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  dbg_last_o, dbg_busy_o
    );

    modport slave (
        input  dbg_req_i, dbg_we_i, dbg_burst_i,
        input  dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output dbg_last_o, dbg_busy_o
    );
endinterface

// File: rtl/riscv_csr_dbg_master.sv
// Debug-side initiator on the CSR port: single reads/writes and PCCR burst
// reads, yielding every cycle to core CSR traffic.
module riscv_csr_dbg_master #(
    parameter int N_PCCR     = 11,
    parameter int STARVE_LIM = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    riscv_csr_dbg_master_if.slave        dbg,
    input  logic                         core_csr_access_i,
    input  logic [11:0]                  core_csr_addr_i,
    input  logic [31:0]                  core_csr_wdata_i,
    input  logic [1:0]                   core_csr_op_i,
    output logic                         csr_access_o,
    output logic [11:0]                  csr_addr_o,
    output logic [31:0]                  csr_wdata_o,
    output logic [1:0]                   csr_op_o,
    input  logic [31:0]                  csr_rdata_i,
    output logic                         stall_req_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BURST
    } state_e;

    localparam logic [1:0]  OP_NONE   = 2'b00;
    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam logic [11:0] PCCR_BASE = 12'h780;
    localparam logic [4:0]  IDX_LAST  = 5'(N_PCCR - 1);
    localparam logic [7:0]  LIM       = 8'(STARVE_LIM);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rvalid_q, rvalid_d;
    logic        last_q, last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        gnt;
    logic        blocked;
    logic [7:0]  cnt_inc;

    // The core owns the port whenever it asks for it.
    assign blocked = core_csr_access_i;
    assign cnt_inc = (cnt_q == LIM) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        last_d   = 1'b0;
        rdata_d  = rdata_q;
        gnt      = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt   = dbg.dbg_req_i;
                cnt_d = '0;
                if (dbg.dbg_req_i) begin
                    we_d    = dbg.dbg_we_i;
                    addr_d  = dbg.dbg_addr_i;
                    wdata_d = dbg.dbg_wdata_i;
                    idx_d   = '0;
                    state_d = dbg.dbg_burst_i ? BURST : ISSUE;
                end
            end
            ISSUE: begin
                if (blocked) begin
                    cnt_d = cnt_inc;
                end else begin
                    rdata_d  = csr_rdata_i;
                    rvalid_d = 1'b1;
                    last_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            BURST: begin
                if (blocked) begin
                    cnt_d = cnt_inc;
                end else begin
                    rdata_d  = csr_rdata_i;
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    if (idx_q == IDX_LAST) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        csr_access_o = 1'b0;
        csr_addr_o   = '0;
        csr_wdata_o  = '0;
        csr_op_o     = OP_NONE;
        if (blocked) begin
            csr_access_o = 1'b1;
            csr_addr_o   = core_csr_addr_i;
            csr_wdata_o  = core_csr_wdata_i;
            csr_op_o     = core_csr_op_i;
        end else if (state_q == ISSUE) begin
            csr_access_o = 1'b1;
            csr_addr_o   = addr_q;
            csr_wdata_o  = wdata_q;
            csr_op_o     = we_q ? OP_WRITE : OP_NONE;
        end else if (state_q == BURST) begin
            csr_access_o = 1'b1;
            csr_addr_o   = PCCR_BASE + {7'd0, idx_q};
            csr_wdata_o  = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            last_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg.dbg_gnt_o    = gnt;
    assign dbg.dbg_rvalid_o = rvalid_q;
    assign dbg.dbg_rdata_o  = rdata_q;
    assign dbg.dbg_last_o   = last_q;
    assign dbg.dbg_busy_o   = (state_q != IDLE) | rvalid_q;
    assign stall_req_o      = (cnt_q == LIM) & (state_q != IDLE);

endmodule
